// File: rtl/noise_cdf_sampler.sv
// Inverse-CDF noise sampler: LFSR uniform draw, binary search over a cumulative
// table read through a 64-bit Avalon read port, one signed sample per handshake.
module noise_cdf_sampler #(
  parameter logic [13:0] TABLE_BASE   = 14'd0,
  parameter int unsigned LOG2_ENTRIES = 8,
  parameter logic [31:0] SEED         = 32'h1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    seed_load,
  input  logic [31:0]             seed,
  output logic [13:0]             mem_address,
  output logic                    mem_chipselect,
  output logic                    mem_write,
  output logic [7:0]              mem_byteenable,
  input  logic [63:0]             mem_readdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [LOG2_ENTRIES-1:0] out_index,
  output logic [31:0]             sample_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_P_ISSUE = 3'd1;
  localparam logic [2:0] S_P_CAPT  = 3'd2;
  localparam logic [2:0] S_F_ISSUE = 3'd3;
  localparam logic [2:0] S_F_CAPT  = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]              r_state;
  logic [31:0]             r_lfsr;
  logic [31:0]             r_rand;
  logic [LOG2_ENTRIES-1:0] r_lo;
  logic [LOG2_ENTRIES-1:0] r_hi;
  logic [3:0]              r_probe;
  logic                    r_valid;
  logic [31:0]             r_data;
  logic [LOG2_ENTRIES-1:0] r_index;
  logic [31:0]             r_count;

  logic [LOG2_ENTRIES:0]   w_sum;
  logic [LOG2_ENTRIES-1:0] w_mid;
  logic [LOG2_ENTRIES-1:0] w_idx;
  logic                    w_cs;
  logic [31:0]             w_lfsr_next;
  logic                    w_accept;

  assign w_sum       = {1'b0, r_lo} + {1'b0, r_hi};
  assign w_mid       = w_sum[LOG2_ENTRIES:1];
  assign w_idx       = (r_state == S_F_ISSUE) ? r_lo : w_mid;
  assign w_cs        = (r_state == S_P_ISSUE) || (r_state == S_F_ISSUE);
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 32'h80200003 : 32'h0);
  assign w_accept    = (r_state == S_IDLE) && enable;

  // The RAM registers address/chipselect itself, so these are driven straight from state.
  assign mem_chipselect = w_cs;
  assign mem_address    = w_cs ? (TABLE_BASE + 14'(w_idx)) : '0;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;

  assign out_valid    = r_valid;
  assign out_data     = r_data;
  assign out_index    = r_index;
  assign sample_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_rand  <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_probe <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_count <= '0;
    end else begin
      if (seed_load)
        r_lfsr <= (seed == 32'h0) ? 32'h1 : seed;
      else if (w_accept)
        r_lfsr <= w_lfsr_next;

      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_rand  <= r_lfsr;
            r_lo    <= '0;
            r_hi    <= '1;
            r_probe <= '0;
            r_state <= S_P_ISSUE;
          end
        end
        S_P_ISSUE: r_state <= S_P_CAPT;
        S_P_CAPT: begin
          if (r_rand <= mem_readdata[31:0])
            r_hi <= w_mid;
          else
            r_lo <= w_mid + LOG2_ENTRIES'(1);
          // The range halves exactly each probe, so L probes always converge lo onto hi.
          if (r_probe == 4'(LOG2_ENTRIES - 1)) begin
            r_probe <= '0;
            r_state <= S_F_ISSUE;
          end else begin
            r_probe <= r_probe + 4'd1;
            r_state <= S_P_ISSUE;
          end
        end
        S_F_ISSUE: r_state <= S_F_CAPT;
        S_F_CAPT: begin
          r_data  <= mem_readdata[63:32];
          r_index <= r_lo;
          r_valid <= 1'b1;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + 32'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_cdf_sampler.sv
// Bench for noise_cdf_sampler: two instances (table base 0 and a wrapping base)
// fed by behavioural RAM models, checked against a linear-scan inverse-CDF model.
module tb_noise_cdf_sampler;

  logic        clk = 1'b0;
  logic        reset, enable, seed_load, out_ready;
  logic [31:0] seed;

  logic [13:0] mem_address, mem_address2;
  logic        mem_chipselect, mem_chipselect2, mem_write, mem_write2;
  logic [7:0]  mem_byteenable, mem_byteenable2;
  logic [63:0] rd1, rd2;
  logic        out_valid, out_valid2;
  logic [31:0] out_data, out_data2, sample_count, sample_count2;
  logic [7:0]  out_index, out_index2;

  noise_cdf_sampler #(.TABLE_BASE(14'd0), .LOG2_ENTRIES(8), .SEED(32'h1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_readdata(rd1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .sample_count(sample_count));

  noise_cdf_sampler #(.TABLE_BASE(14'h3F80), .LOG2_ENTRIES(8), .SEED(32'h1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .mem_address(mem_address2), .mem_chipselect(mem_chipselect2), .mem_write(mem_write2),
    .mem_byteenable(mem_byteenable2), .mem_readdata(rd2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_index(out_index2), .sample_count(sample_count2));

  always #5 clk = ~clk;

  logic [31:0] cdf [256];
  logic [31:0] val [256];

  // RAM models: address registered on the edge, data garbage when not read.
  always @(posedge clk) begin
    logic [13:0] off;
    if (mem_chipselect) rd1 <= {val[mem_address[7:0]], cdf[mem_address[7:0]]};
    else                rd1 <= {$urandom, $urandom};
    off = mem_address2 - 14'h3F80;
    if (mem_chipselect2) rd2 <= {val[off[7:0]], cdf[off[7:0]]};
    else                 rd2 <= {$urandom, $urandom};
  end

  int          n_reads = 0, n_consec = 0;
  logic        prev_cs = 1'b0;
  logic [13:0] last_addr = '0, last_addr2 = '0;

  always @(negedge clk) begin
    if (mem_chipselect) begin
      n_reads++;
      last_addr = mem_address;
      if (prev_cs) n_consec++;
    end
    prev_cs = mem_chipselect;
    if (mem_chipselect2) last_addr2 = mem_address2;
  end

  int          n_checks = 0, n_pass = 0;
  logic [31:0] m_lfsr;
  logic [31:0] m_count;
  logic [31:0] m_rand;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic int ref_index(input logic [31:0] r);
    for (int i = 0; i < 256; i++) if (r <= cdf[i]) return i;
    return 255;
  endfunction

  task automatic set_uniform();
    for (int i = 0; i < 256; i++) begin
      cdf[i] = 32'((i + 1) * 64'd16777216 - 1);
      val[i] = 32'(i - 128);
    end
  endtask

  task automatic set_random_table();
    longint c = 0;
    for (int i = 0; i < 255; i++) begin
      if ($urandom_range(0, 3) != 0) c += $urandom_range(0, 33554432);
      if (c > 64'hFFFFFFFF) c = 64'hFFFFFFFF;
      cdf[i] = 32'(c);
      val[i] = $urandom;
    end
    cdf[255] = 32'hFFFFFFFF;
    val[255] = $urandom;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed = s; seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    m_lfsr = (s == 32'h0) ? 32'h1 : s;
  endtask

  // Called at #1 after an edge with the DUT idle; leaves m_rand = the draw used.
  task automatic do_sample(output logic [7:0] idx, output logic [31:0] data,
                           output logic [7:0] idx2, output int lat);
    n_reads = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL sample_timeout: out_valid=%0b after 200 cycles, required 1", out_valid);
    end
    idx = out_index; data = out_data; idx2 = out_index2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_rand = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    m_count++;
  endtask

  task automatic test_reset();
    logic [7:0] i, i2; logic [31:0] d; int lat;
    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_lfsr = 32'h1; m_count = 0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_index !== 8'h0) $display("FAIL reset_index: got %h want 0", out_index); else n_pass++;
    n_checks++; if (sample_count !== 32'h0) $display("FAIL reset_count: got %0d want 0", sample_count); else n_pass++;
    n_checks++; if (mem_chipselect !== 1'b0) $display("FAIL reset_cs: got %0b want 0", mem_chipselect); else n_pass++;
    n_checks++; if (mem_address !== 14'h0) $display("FAIL reset_addr: got %h want 0", mem_address); else n_pass++;
    n_checks++; if (mem_write !== 1'b0 || mem_byteenable !== 8'hFF)
      $display("FAIL tie_offs: write=%0b be=%h want 0/FF", mem_write, mem_byteenable); else n_pass++;
    set_uniform();
    do_sample(i, d, i2, lat);
    n_checks++; if (m_rand !== 32'h1) $display("FAIL model_first_rand: got %h want 1", m_rand); else n_pass++;
    n_checks++; if (i !== 8'h0 || d !== 32'hFFFFFF80)
      $display("FAIL first_sample: idx=%h data=%h want 00/ffffff80", i, d); else n_pass++;
  endtask

  task automatic test_uniform();
    logic [7:0] i, i2; logic [31:0] d; int lat;
    load_seed(32'h5A00_0000);
    do_sample(i, d, i2, lat);
    n_checks++; if (i !== 8'h5A) $display("FAIL uniform_index: got %h want 5a", i); else n_pass++;
    n_checks++; if ($signed(d) !== -32'sd38) $display("FAIL uniform_data: got %0d want -38", $signed(d)); else n_pass++;
    n_checks++; if (lat !== 18) $display("FAIL latency: got %0d want 18", lat); else n_pass++;
    n_checks++; if (n_reads !== 9) $display("FAIL read_count: got %0d want 9", n_reads); else n_pass++;
    n_checks++; if (last_addr !== 14'h005A) $display("FAIL final_addr: got %h want 005a", last_addr); else n_pass++;
    n_checks++; if (last_addr2 !== 14'h3FDA) $display("FAIL final_addr_base: got %h want 3fda", last_addr2); else n_pass++;
    n_checks++; if (i2 !== 8'h5A) $display("FAIL uniform_index_base: got %h want 5a", i2); else n_pass++;
  endtask

  task automatic test_bounds();
    logic [7:0] i, i2; logic [31:0] d; int lat;
    load_seed(32'h0);
    do_sample(i, d, i2, lat);
    n_checks++; if (i !== 8'h00 || i2 !== 8'h00) $display("FAIL seed_zero: idx=%h/%h want 00", i, i2); else n_pass++;
    load_seed(32'hFFFF_FFFF);
    do_sample(i, d, i2, lat);
    n_checks++; if (i !== 8'hFF || d !== 32'h7F) $display("FAIL seed_ones: idx=%h data=%h want ff/7f", i, d); else n_pass++;
    n_checks++; if (last_addr2 !== 14'h007F || i2 !== 8'hFF)
      $display("FAIL addr_wrap: addr=%h idx=%h want 007f/ff", last_addr2, i2); else n_pass++;
  endtask

  task automatic test_zero_prob();
    logic [7:0] i, i2; logic [31:0] d; int lat;
    set_uniform();
    for (int k = 10; k <= 20; k++) cdf[k] = 32'h0B00_0000;
    load_seed(32'h0B00_0000);
    do_sample(i, d, i2, lat);
    n_checks++; if (i !== 8'd10 || ref_index(m_rand) != 10)
      $display("FAIL zero_prob_run: idx=%0d want 10", i); else n_pass++;
    set_uniform();
  endtask

  task automatic test_backpressure();
    logic [7:0] i, i2, ci; logic [31:0] d, cd; int lat, rc, bad; bit seen;
    load_seed(32'hC0FF_EE01);
    n_reads = 0; seen = 0; bad = 0;
    enable = 1'b1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    m_rand = m_lfsr; m_lfsr = lfsr_next(m_lfsr);
    n_checks++; if (!seen) $display("FAIL bp_timeout: out_valid=%0b want 1", out_valid); else n_pass++;
    cd = out_data; ci = out_index; rc = n_reads;
    n_checks++; if (ci !== 8'(ref_index(m_rand)) || cd !== val[ref_index(m_rand)])
      $display("FAIL bp_result: idx=%h data=%h want %h/%h", ci, cd, 8'(ref_index(m_rand)), val[ref_index(m_rand)]); else n_pass++;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== cd || out_index !== ci || sample_count !== m_count) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles want 0", bad); else n_pass++;
    n_checks++; if (n_reads !== rc) $display("FAIL bp_no_reads: got %0d extra reads want 0", n_reads - rc); else n_pass++;
    enable = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; m_count++;
    n_checks++; if (out_valid !== 1'b0 || sample_count !== m_count)
      $display("FAIL bp_handshake: valid=%0b count=%0d want 0/%0d", out_valid, sample_count, m_count); else n_pass++;
    do_sample(i, d, i2, lat);
    n_checks++; if (i !== 8'(ref_index(m_rand)))
      $display("FAIL bp_lfsr_once: idx=%h want %h", i, 8'(ref_index(m_rand))); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    logic [7:0] i1 = '0, i2 = '0; logic [31:0] r1, r2;
    load_seed(32'h1234_5678);
    enable = 1'b1; out_ready = 1'b1;
    for (int n = 1; n <= 200 && second < 0; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (first < 0) begin first = n; i1 = out_index; end
        else begin second = n; i2 = out_index; end
      end
    end
    enable = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    r1 = m_lfsr; m_lfsr = lfsr_next(m_lfsr);
    r2 = m_lfsr; m_lfsr = lfsr_next(m_lfsr);
    m_count += 2;
    n_checks++; if (second - first != 20) $display("FAIL throughput: period=%0d want 20", second - first); else n_pass++;
    n_checks++; if (i1 !== 8'(ref_index(r1)) || i2 !== 8'(ref_index(r2)))
      $display("FAIL b2b_index: got %h %h want %h %h", i1, i2, 8'(ref_index(r1)), 8'(ref_index(r2))); else n_pass++;
    n_checks++; if (sample_count !== m_count) $display("FAIL b2b_count: got %0d want %0d", sample_count, m_count); else n_pass++;
    n_checks++; if (n_consec !== 0) $display("FAIL cs_consecutive: got %0d want 0", n_consec); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] i, i2; logic [31:0] d; int lat, e;
    set_random_table();
    load_seed($urandom | 32'h1);
    for (int k = 0; k < 12; k++) begin
      do_sample(i, d, i2, lat);
      e = ref_index(m_rand);
      n_checks++; if (i !== 8'(e) || d !== val[e] || i2 !== 8'(e))
        $display("FAIL random_sample[%0d]: rand=%h idx=%h/%h data=%h want %h/%h", k, m_rand, i, i2, d, 8'(e), val[e]);
      else n_pass++;
      n_checks++; if (n_reads !== 9) $display("FAIL random_reads[%0d]: got %0d want 9", k, n_reads); else n_pass++;
    end
    n_checks++; if (sample_count !== m_count) $display("FAIL random_count: got %0d want %0d", sample_count, m_count); else n_pass++;
    set_uniform();
  endtask

  task automatic test_reset_midsearch();
    logic [7:0] i, i2; logic [31:0] d; int lat;
    load_seed(32'hC000_0000);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_lfsr = 32'h1; m_count = 0;
    n_checks++; if (mem_chipselect !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL mid_reset_outputs: cs=%0b valid=%0b want 0/0", mem_chipselect, out_valid); else n_pass++;
    n_checks++; if (sample_count !== 32'h0) $display("FAIL mid_reset_count: got %0d want 0", sample_count); else n_pass++;
    do_sample(i, d, i2, lat);
    n_checks++; if (i !== 8'(ref_index(32'h1)) || d !== val[ref_index(32'h1)])
      $display("FAIL mid_reset_seed: idx=%h data=%h want %h/%h", i, d, 8'(ref_index(32'h1)), val[ref_index(32'h1)]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_bounds();
    test_zero_prob();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midsearch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noise_cdf_sampler.md
# noise_cdf_sampler

Draws noise samples for the SERDES channel model by inverse-CDF lookup in the noise-probability table held in the dual-port on-chip memory. It owns that memory's 64-bit second port as a read-only Avalon master, generates a 32-bit uniform random number with an internal LFSR, and binary-searches the cumulative table for it. It emits one signed 32-bit noise value per valid/ready handshake to the downstream noise-injection stage. The Nios core owns the table contents through the 32-bit port and seeds the LFSR through this block.

## Interface
- TABLE_BASE, 14'd0: 64-bit word address of table entry 0 on the memory's second port.
- LOG2_ENTRIES, 8: table holds 2^LOG2_ENTRIES entries; range 1..13.
- SEED, 32'h1: LFSR reset value; must be nonzero.
- clk  in  1  sole clock; the memory's second-port clock is driven from the same net.
- reset  in  1  synchronous, active-high.
- enable  in  1  request a new sample when idle.
- seed_load  in  1  load `seed` into the LFSR.
- seed  in  32  seed value.
- mem_address  out  14  second-port word address.
- mem_chipselect  out  1  read strobe.
- mem_write  out  1  tied 0.
- mem_byteenable  out  8  tied 8'hFF.
- mem_readdata  in  64  entry word: [63:32] signed noise value; [31:0] unsigned cumulative threshold (nondecreasing; last entry 32'hFFFFFFFF).
- out_valid  out  1  sample available.
- out_ready  in  1  downstream accepts.
- out_data  out  32  signed noise value.
- out_index  out  LOG2_ENTRIES  selected table index.
- sample_count  out  32  completed handshakes, wraps at 2^32.

## Operation
- Memory port: address and chipselect are registered inside the RAM and its output is unregistered. `mem_readdata` is valid on the cycle after the cycle in which `mem_chipselect`=1.
- `mem_address` = (TABLE_BASE + idx) mod 2^14 while `mem_chipselect`=1. It is 0 otherwise.
- LFSR: 32-bit Galois right-shift. Next value = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0).
- LFSR advance: once per accepted request, and only then.
- seed_load: takes priority over advance, in any state. A seed of 0 loads 32'h1.
- FSM states: IDLE, P_ISSUE, P_CAPT, F_ISSUE, F_CAPT, HOLD.
- IDLE with enable=1:
  - rand <= lfsr, captured before any seed_load or advance in that cycle.
  - lo <= 0; hi <= 2^L-1.
  - Go to P_ISSUE.
- P_ISSUE: chipselect=1, idx = mid = (lo+hi)>>1. Go to P_CAPT.
- P_CAPT:
  - If rand <= readdata[31:0], hi <= mid; else lo <= mid+1.
  - After exactly LOG2_ENTRIES probes go to F_ISSUE; otherwise go to P_ISSUE.
- Search result: lo is the smallest index with rand <= cdf[index].
- F_ISSUE: chipselect=1, idx = lo. Go to F_CAPT.
- F_CAPT:
  - out_data <= readdata[63:32]; out_index <= lo.
  - out_valid <= 1. Go to HOLD.
- HOLD: outputs held stable with no memory access. On out_ready=1: out_valid <= 0, sample_count += 1, go to IDLE.
- Unsorted tables give a defined but meaningless index. Detecting them is not required.
- Reset, including mid-search:
  - State goes to IDLE and any pending result is discarded.
  - lfsr=SEED; out_valid=0, out_data=0, out_index=0, sample_count=0.
  - mem_chipselect=0, mem_address=0.

## Timing
- Latency: the edge that accepts a request in IDLE is edge 0. out_valid rises on edge 2*LOG2_ENTRIES+2, which is edge 18 for L=8.
- Throughput: with out_ready held at 1, one sample every 2*LOG2_ENTRIES+4 cycles (20 for L=8).
- Memory reads per sample: exactly LOG2_ENTRIES+1, each with a one-cycle chipselect pulse. chipselect is never asserted on consecutive cycles.
- enable is ignored outside IDLE. The output holds indefinitely under backpressure.

## Test plan
- Reset: hold reset 3 cycles → every output is 0, state is IDLE, and the first sample with no seed_load uses rand=32'h1.
- Uniform table (L=8, cdf[i]=(i+1)*2^24-1, value[i]=i-128), seed 32'h5A00_0000, enable for one sample → out_index=8'h5A, out_data=-38, out_valid on edge 18, 9 reads with the final read at address 0x5A.
- Bounds:
  - seed 32'h0 → rand=1 → index 0.
  - seed 32'hFFFF_FFFF → index 255.
  - TABLE_BASE=14'h3F80 → addresses wrap past 14'h3FFF to 0.
- Zero-probability run (cdf[10..20] all equal to X), rand=X → index 10.
- Backpressure: out_ready=0 for 50 cycles → out_data and out_index stable, no chipselect, LFSR unchanged, sample_count unchanged until the handshake, then +1.
- Reset asserted on the third P_CAPT → the next cycle has chipselect=0 and out_valid=0. The next request produces the sample for rand=SEED.
